// File: rtl/fpu_add_pkg.sv
// Shared widths, limits and the S1->S2 payload of the FP32 adder normalize/round stage.
package fpu_add_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned MENT_WIDTH     = 23;
    localparam int unsigned EXPO_WIDTH     = 8;
    localparam int unsigned SHIFT_WIDTH    = $clog2(MENT_WIDTH) + 1;
    localparam int unsigned EXP_CALC_WIDTH = EXPO_WIDTH + 2;

    localparam logic [EXPO_WIDTH-1:0] EXP_MAX  = 8'hFF;
    localparam int                    EXP_BIAS = 127;

    typedef logic signed [EXP_CALC_WIDTH-1:0] exp_t;

    typedef struct packed {
        logic                sign;
        exp_t                exp;
        logic [MENT_WIDTH:0] mant;
        logic                guard;
        logic                zero;
    } s1_payload_t;

endpackage

// File: rtl/addition_normalize_round_stage_if.sv
// Upstream operand bus and downstream result bus of the normalize/round stage.
interface addition_normalize_round_stage_if;
    import fpu_add_pkg::*;

    logic                   valid_in;
    logic                   ready_out;
    logic                   sign_in;
    logic [EXPO_WIDTH-1:0]  exponent_in;
    logic                   carry_in;
    logic [MENT_WIDTH:0]    addition_in;
    logic [SHIFT_WIDTH-1:0] normalize_position_in;
    logic                   valid_out;
    logic                   ready_in;
    logic [DATA_WIDTH-1:0]  floating_out;
    logic                   overflow_out;
    logic                   underflow_out;
    logic                   zero_out;

    modport master (
        output valid_in, sign_in, exponent_in, carry_in, addition_in, normalize_position_in,
        output ready_in,
        input  ready_out, valid_out, floating_out, overflow_out, underflow_out, zero_out
    );

    modport slave (
        input  valid_in, sign_in, exponent_in, carry_in, addition_in, normalize_position_in,
        input  ready_in,
        output ready_out, valid_out, floating_out, overflow_out, underflow_out, zero_out
    );

endinterface

// File: rtl/mentissa_round_unit.sv
// Round-to-nearest-even increment of a normalized mantissa with a single guard bit.
module mentissa_round_unit
    import fpu_add_pkg::*;
(
    input  logic [MENT_WIDTH:0]   i_mant,
    input  logic                  i_guard,
    output logic [MENT_WIDTH-1:0] o_frac,
    output logic                  o_carry
);

    logic w_inc;
    logic w_frac_carry;

    assign w_inc = i_guard & i_mant[0];
    assign {w_frac_carry, o_frac} = {1'b0, i_mant[MENT_WIDTH-1:0]} + {{MENT_WIDTH{1'b0}}, w_inc};
    // The hidden bit is set on every rounded value, so a fraction wrap overflows the mantissa.
    assign o_carry = w_frac_carry & i_mant[MENT_WIDTH];

endmodule

// File: rtl/addition_normalize_round_stage.sv
// FP32 adder stage 4: S1 normalizes the mantissa sum, S2 rounds (RNE) and packs with status flags.
module addition_normalize_round_stage
    import fpu_add_pkg::*;
(
    input logic                             clk_in,
    input logic                             rst_in,
    addition_normalize_round_stage_if.slave bus
);

    logic                  w_s2_adv;
    logic                  w_s1_adv;
    exp_t                  w_exp_in;
    s1_payload_t           w_s1_next;
    logic                  r_s1_valid;
    s1_payload_t           r_s1;
    logic [MENT_WIDTH-1:0] w_frac;
    logic                  w_rnd_carry;
    exp_t                  w_exp_rnd;
    logic [DATA_WIDTH-1:0] w_float;
    logic                  w_ovf;
    logic                  w_unf;
    logic                  w_zero;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_float;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_zero;

    assign w_s2_adv      = !r_s2_valid || bus.ready_in;
    assign w_s1_adv      = !r_s1_valid || w_s2_adv;
    assign bus.ready_out = w_s1_adv;

    assign w_exp_in = $signed({2'b00, bus.exponent_in});

    always_comb begin
        w_s1_next      = '0;
        w_s1_next.sign = bus.sign_in;
        w_s1_next.zero = !bus.carry_in && (bus.addition_in == '0);
        if (bus.carry_in) begin
            w_s1_next.mant  = {1'b1, bus.addition_in[MENT_WIDTH:1]};
            w_s1_next.guard = bus.addition_in[0];
            w_s1_next.exp   = w_exp_in + exp_t'(1);
        end else begin
            w_s1_next.mant = bus.addition_in << bus.normalize_position_in;
            w_s1_next.exp  = w_exp_in -
                $signed({{(EXP_CALC_WIDTH-SHIFT_WIDTH){1'b0}}, bus.normalize_position_in});
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    mentissa_round_unit u_round (
        .i_mant  (r_s1.mant),
        .i_guard (r_s1.guard),
        .o_frac  (w_frac),
        .o_carry (w_rnd_carry)
    );

    assign w_exp_rnd = r_s1.exp + $signed({{(EXP_CALC_WIDTH-1){1'b0}}, w_rnd_carry});

    always_comb begin
        w_float = '0;
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        w_zero  = 1'b0;
        if (r_s1.zero) begin
            w_zero = 1'b1;
        end else if (w_exp_rnd >= exp_t'(EXP_MAX)) begin
            w_float = {r_s1.sign, EXP_MAX, {MENT_WIDTH{1'b0}}};
            w_ovf   = 1'b1;
        end else if (w_exp_rnd <= exp_t'(0)) begin
            // No denormals: anything below the normal range flushes to signed zero.
            w_float = {r_s1.sign, {(DATA_WIDTH-1){1'b0}}};
            w_unf   = 1'b1;
        end else begin
            w_float = {r_s1.sign, w_exp_rnd[EXPO_WIDTH-1:0], w_frac};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s2_valid <= 1'b0;
            r_float    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_float <= w_float;
                r_ovf   <= w_ovf;
                r_unf   <= w_unf;
                r_zero  <= w_zero;
            end
        end
    end

    assign bus.valid_out     = r_s2_valid;
    assign bus.floating_out  = r_float;
    assign bus.overflow_out  = r_ovf;
    assign bus.underflow_out = r_unf;
    assign bus.zero_out      = r_zero;

endmodule
